// File: rtl/ias_pkg.sv
// Shared IAS constants: widths, halfword fields, fetch FSM states, opcodes.
// Imported by the fetch stage and the control unit.
package ias_pkg;

  localparam int ADDR_W = 12;
  localparam int WORD_W = 40;
  localparam int OPC_W  = 8;
  localparam int HALF_W = OPC_W + ADDR_W;

  localparam int L_OPC_HI = 39;
  localparam int L_OPC_LO = 32;
  localparam int L_ADR_HI = 31;
  localparam int L_ADR_LO = 20;
  localparam int R_OPC_HI = 19;
  localparam int R_OPC_LO = 12;
  localparam int R_ADR_HI = 11;
  localparam int R_ADR_LO = 0;

  typedef enum logic {
    IDLE,
    WAIT
  } fetch_state_t;

  localparam logic [OPC_W-1:0] OP_LOAD  = 8'd1;
  localparam logic [OPC_W-1:0] OP_STORE = 8'd2;
  localparam logic [OPC_W-1:0] OP_ADD   = 8'd3;
  localparam logic [OPC_W-1:0] OP_SUB   = 8'd4;
  localparam logic [OPC_W-1:0] OP_JUMP  = 8'd5;

endpackage

// File: rtl/ias_fetch_unit_ibr.sv
// Instruction buffer register: one 20-bit right-half instruction plus valid.
// Clear and consume both drop the valid bit; load sets it.
import ias_pkg::*;

module ias_ibr (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_consume,
  input  logic [HALF_W-1:0] i_data,
  output logic [HALF_W-1:0] o_data,
  output logic              o_valid
);

  logic [HALF_W-1:0] r_data;
  logic              r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_clear || i_consume)
        r_valid <= 1'b0;
      else if (i_load)
        r_valid <= 1'b1;
      if (i_load)
        r_data <= i_data;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/ias_fetch_unit.sv
// IAS fetch stage: PC, IR/MAR and IBR; left halves from memory,
// right halves from the IBR (or from memory after a right-half jump).
import ias_pkg::*;

module ias_fetch_unit (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              jump_right,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] operand_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic              busy
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [OPC_W-1:0]  r_opcode;
  logic [ADDR_W-1:0] r_mar;
  logic              r_mem_rd;
  logic              r_busy;
  logic              r_instr_valid;
  logic              r_right_pending;

  logic [HALF_W-1:0] w_ibr;
  logic              w_ibr_valid;
  logic              w_idle;
  logic              w_jump;
  logic              w_fetch;
  logic              w_hit;
  logic              w_miss;
  logic              w_done;
  logic              w_ibr_load;

  assign w_idle     = (r_state == IDLE);
  assign w_jump     = w_idle & jump_en;
  assign w_fetch    = w_idle & ~jump_en & fetch_req;
  assign w_hit      = w_fetch & w_ibr_valid;
  assign w_miss     = w_fetch & ~w_ibr_valid;
  assign w_done     = (r_state == WAIT) & mem_valid;
  assign w_ibr_load = w_done & ~r_right_pending;

  ias_ibr u_ibr (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_ibr_load),
    .i_clear   (w_jump),
    .i_consume (w_hit),
    .i_data    (mem_rdata[R_OPC_HI:R_ADR_LO]),
    .o_data    (w_ibr),
    .o_valid   (w_ibr_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_pc            <= '0;
      r_mem_addr      <= '0;
      r_opcode        <= '0;
      r_mar           <= '0;
      r_mem_rd        <= 1'b0;
      r_busy          <= 1'b0;
      r_instr_valid   <= 1'b0;
      r_right_pending <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      unique case (1'b1)
        w_jump: begin
          r_pc            <= jump_addr;
          r_right_pending <= jump_right;
        end
        w_hit: begin
          r_opcode      <= w_ibr[R_OPC_HI:R_OPC_LO];
          r_mar         <= w_ibr[R_ADR_HI:R_ADR_LO];
          r_pc          <= r_pc + ADDR_W'(1);
          r_instr_valid <= 1'b1;
        end
        w_miss: begin
          r_mem_addr <= r_pc;
          r_mem_rd   <= 1'b1;
          r_busy     <= 1'b1;
          r_state    <= WAIT;
        end
        w_done: begin
          r_mem_rd      <= 1'b0;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
          r_instr_valid <= 1'b1;
          if (r_right_pending) begin
            r_opcode        <= mem_rdata[R_OPC_HI:R_OPC_LO];
            r_mar           <= mem_rdata[R_ADR_HI:R_ADR_LO];
            r_pc            <= r_pc + ADDR_W'(1);
            r_right_pending <= 1'b0;
          end else begin
            r_opcode <= mem_rdata[L_OPC_HI:L_OPC_LO];
            r_mar    <= mem_rdata[L_ADR_HI:L_ADR_LO];
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_rd       = r_mem_rd;
  assign mem_addr     = r_mem_addr;
  assign opcode       = r_opcode;
  assign operand_addr = r_mar;
  assign pc           = r_pc;
  assign instr_valid  = r_instr_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_ias_fetch_unit.sv
// Scoreboard bench for ias_fetch_unit: instruction-stream model,
// randomized memory latency, directed corner cases plus random ops.
module tb_ias_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic        jump_en;
  logic [11:0] jump_addr;
  logic        jump_right;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [39:0] mem_rdata;
  logic        mem_valid;
  logic [7:0]  opcode;
  logic [11:0] operand_addr;
  logic [11:0] pc;
  logic        instr_valid;
  logic        busy;

  always #5 clk = ~clk;

  ias_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .jump_right   (jump_right),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_valid    (mem_valid),
    .opcode       (opcode),
    .operand_addr (operand_addr),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0]  opc;
    logic [11:0] adr;
    logic [11:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] rd_q[$];
  logic [39:0] mem [4096];

  int checks = 0;
  int errors = 0;

  // responder controls
  logic hold = 1'b0;
  logic inj  = 1'b0;

  // reference model: program position and buffered right half
  logic [11:0] m_pc;
  logic        m_right;
  logic        m_buf;
  logic [19:0] m_half;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic push_exp(input logic [19:0] h, input logic [11:0] p);
    exp_t e;
    e.opc = h[19:12];
    e.adr = h[11:0];
    e.pc  = p;
    exp_q.push_back(e);
  endtask

  task automatic model_fetch(output bit hit);
    logic [39:0] w;
    if (m_buf) begin
      hit = 1;
      push_exp(m_half, m_pc + 12'd1);
      m_pc  = m_pc + 12'd1;
      m_buf = 0;
    end else begin
      hit = 0;
      w   = mem[m_pc];
      rd_q.push_back(m_pc);
      if (m_right) begin
        push_exp(w[19:0], m_pc + 12'd1);
        m_pc    = m_pc + 12'd1;
        m_right = 0;
      end else begin
        push_exp(w[39:20], m_pc);
        m_half = w[19:0];
        m_buf  = 1;
      end
    end
  endtask

  task automatic model_reset();
    m_pc    = '0;
    m_right = 0;
    m_buf   = 0;
    m_half  = '0;
  endtask

  // memory responder: sole driver of mem_valid / mem_rdata
  initial begin
    int wc;
    logic [63:0] r;
    wc        = 0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (reset) wc = 0;
      if (inj) begin
        r         = {$urandom, $urandom};
        mem_valid = 1'b1;
        mem_rdata = r[39:0];
      end else if (mem_rd && !hold && !reset) begin
        if (wc == 0) begin
          mem_valid = 1'b1;
          mem_rdata = mem[mem_addr];
          wc        = $urandom_range(0, 3);
        end else begin
          wc--;
        end
      end
    end
  end

  // instruction monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr_valid actual=1 expected=0");
        end else begin
          e = exp_q.pop_front();
          chk("opcode", opcode, e.opc);
          chk("operand_addr", operand_addr, e.adr);
          chk("pc", pc, e.pc);
        end
      end
    end
  end

  // read monitor
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd && !prev) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read actual=%0h expected=none",
                   mem_addr);
        end else begin
          chk("mem_addr", mem_addr, rd_q.pop_front());
          chk("busy", busy, 1);
        end
      end
      prev = mem_rd;
    end
  end

  task automatic do_fetch(input bit extra);
    bit hit;
    int k;
    @(negedge clk);
    fetch_req = 1'b1;
    model_fetch(hit);
    @(negedge clk);
    fetch_req = 1'b0;
    k = 0;
    while (!instr_valid && k < 20) begin
      if (extra && k == 0) begin
        fetch_req  = 1'b1;
        jump_en    = 1'b1;
        jump_addr  = 12'($urandom);
        jump_right = 1'($urandom);
      end
      @(negedge clk);
      fetch_req = 1'b0;
      jump_en   = 1'b0;
      k++;
    end
    if (k == 20) chk("fetch_timeout", 1, 0);
    else if (hit) chk("hit_latency", k, 0);
    else chk("miss_latency_min", k >= 1, 1);
  endtask

  task automatic do_jump(input logic [11:0] a, input bit r, input bit fr);
    @(negedge clk);
    jump_en    = 1'b1;
    jump_addr  = a;
    jump_right = r;
    fetch_req  = fr;
    m_pc    = a;
    m_right = r;
    m_buf   = 0;
    @(negedge clk);
    jump_en   = 1'b0;
    fetch_req = 1'b0;
    chk("jump_pc", pc, a);
    chk("jump_no_read", mem_rd, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_opcode"}, opcode, 0);
    chk({tag, "_operand"}, operand_addr, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_instr_valid"}, instr_valid, 0);
  endtask

  initial begin
    logic [63:0] r;
    for (int i = 0; i < 4096; i++) begin
      r = {$urandom, $urandom};
      mem[i] = r[39:0];
    end
    mem[0]     = 40'h01_005_03_006;
    mem[12'h020] = 40'h00_000_05_030;
    fetch_req  = 1'b0;
    jump_en    = 1'b0;
    jump_addr  = '0;
    jump_right = 1'b0;
    reset      = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");

    // left from memory, right from IBR
    do_fetch(0);
    do_fetch(0);
    // jump flushes a loaded IBR
    do_fetch(0);
    do_jump(12'h010, 0, 0);
    do_fetch(0);
    // right-half jump, then the next fetch goes to memory
    do_jump(12'h020, 1, 0);
    do_fetch(0);
    do_fetch(0);
    // PC wrap on right-half issue
    do_jump(12'hFFF, 1, 0);
    do_fetch(0);
    do_fetch(0);
    // jump wins over a simultaneous fetch
    do_jump(12'h123, 0, 1);
    @(negedge clk);
    chk("jf_no_read", mem_rd, 0);
    // extra requests during WAIT are ignored
    do_fetch(1);
    do_fetch(0);
    do_fetch(1);

    // reset mid-WAIT, then a stray mem_valid in IDLE
    hold = 1'b1;
    do_jump(12'h200, 0, 0);
    begin
      bit hit;
      @(negedge clk);
      fetch_req = 1'b1;
      model_fetch(hit);
      @(negedge clk);
      fetch_req = 1'b0;
      chk("wait_mem_rd", mem_rd, 1);
      reset = 1'b1;
      #1;
      chk_reset_vals("midrst");
      void'(exp_q.pop_back());
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      hold  = 1'b0;
      inj   = 1'b1;
      @(negedge clk);
      inj = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray_valid_pc", pc, 0);
    end
    do_fetch(0);
    do_fetch(0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 22)
        do_jump(12'($urandom), 1'($urandom), 1'($urandom));
      else
        do_fetch(!m_buf && ($urandom_range(0, 3) == 0));
    end

    repeat (10) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ias_fetch_unit.md
# ias_fetch_unit

Instruction fetch stage of the IAS processor, directly upstream of `control_unit`. It holds the PC and the instruction buffer register (IBR) and reads 40-bit memory words holding two 20-bit instructions (8-bit opcode, 12-bit address). It presents one instruction at a time to `control_unit` as `opcode` plus `operand_addr`. Left halves come from memory; right halves come from the IBR without a memory access.

## Interface
- `ADDR_W`, 12: address width of the PC, MAR and memory.
- `WORD_W`, 40: memory word width.
- `OPC_W`, 8: opcode width.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `fetch_req`  in  1  — single-cycle request to fetch the next instruction; driven by the control unit's `load_ir`.
- `jump_en`  in  1  — load a jump target into the PC; driven by the control unit's `load_pc`.
- `jump_addr`  in  ADDR_W  — jump target word address.
- `jump_right`  in  1  — 1 means execution resumes at the right half of `jump_addr`.
- `mem_rd`  out  1  — memory read request, level.
- `mem_addr`  out  ADDR_W  — memory read address, registered.
- `mem_rdata`  in  WORD_W  — read data; valid only while `mem_valid` is high.
- `mem_valid`  in  1  — read data valid strobe.
- `opcode`  out  OPC_W  — IR contents, fed to the control unit's `opcode`.
- `operand_addr`  out  ADDR_W  — MAR contents, the current instruction's address field.
- `pc`  out  ADDR_W  — program counter.
- `instr_valid`  out  1  — one-cycle pulse when `opcode` and `operand_addr` are updated.
- `busy`  out  1  — high while a memory read is outstanding.

## Operation
- Word layout: left opcode is [39:32], left address is [31:20], right opcode is [19:12], right address is [11:0].
- Internal state: `ibr` (20 bits), `ibr_valid`, `right_pending`, and an FSM with states IDLE and WAIT.
- IDLE, `fetch_req`, `ibr_valid`=1 (IBR hit):
  - IR and MAR load from `ibr`.
  - `ibr_valid` clears; `pc` increments.
  - State stays IDLE.
- IDLE, `fetch_req`, `ibr_valid`=0 (miss):
  - `mem_addr` <= `pc`, `mem_rd` <= 1, `busy` <= 1.
  - State goes to WAIT.
- WAIT, `mem_valid`=1, `right_pending`=0:
  - IR and MAR load from the left half.
  - `ibr` <= right half, `ibr_valid` <= 1; `pc` is unchanged.
- WAIT, `mem_valid`=1, `right_pending`=1:
  - IR and MAR load from the right half.
  - `pc` increments; `ibr_valid` stays 0; `right_pending` clears.
- Both WAIT completions also clear `mem_rd` and `busy` and return to IDLE.
- IDLE, `jump_en`:
  - `pc` <= `jump_addr`, `ibr_valid` <= 0, `right_pending` <= `jump_right`.
  - No fetch starts in that cycle.
- Simultaneous events and ignored inputs:
  - `jump_en` and `fetch_req` in the same cycle: the jump wins and `fetch_req` is dropped. The control unit re-requests.
  - `fetch_req` or `jump_en` during WAIT: ignored.
  - `mem_valid` while in IDLE: ignored.
  - Unknown opcodes pass through unchanged; decoding belongs to `control_unit`.
- PC arithmetic is modulo 2^ADDR_W: 0xFFF + 1 = 0x000.

## Timing
- Reset values:
  - `pc`, `mem_addr`, `opcode`, `operand_addr` are 0.
  - `mem_rd`, `busy`, `instr_valid` are 0.
  - `ibr_valid` and `right_pending` are 0; state is IDLE.
- IBR hit: `instr_valid` pulses in the cycle after `fetch_req`. Total latency is 1 cycle.
- Miss:
  - `mem_rd` is high starting the cycle after `fetch_req` and stays high until the edge that samples `mem_valid`=1.
  - `instr_valid` pulses in the following cycle.
  - Latency is 2 + (memory wait) cycles, minimum 2.
- `opcode` and `operand_addr` hold their values between `instr_valid` pulses.
- Reset mid-WAIT abandons the read. A late `mem_valid` after reset is ignored because the FSM is in IDLE.

## Structure
- Package `ias_pkg` holds:
  - `ADDR_W`, `WORD_W`, `OPC_W`.
  - Halfword bit-field constants.
  - FSM state enum (IDLE, WAIT).
  - Opcode constants: LOAD=1, STORE=2, ADD=3, SUB=4, JUMP=5. These are shared with `control_unit`.
- One natural sub-module, `ias_ibr`: a 20-bit register with valid bit, with load, clear and consume controls.

## Test plan
1. IBR path: reset; word[0]=0x01_005_03_006; `fetch_req`, `mem_valid` 2 cycles later.
   - Expect `opcode`=0x01, `operand_addr`=0x005, `pc`=0.
   - Then `fetch_req` again: expect `opcode`=0x03, `operand_addr`=0x006 one cycle later, `mem_rd` never high, `pc`=1.
2. Jump flushes the IBR: while `ibr_valid`=1, `jump_en`, `jump_addr`=0x010, `jump_right`=0.
   - Next `fetch_req` reads address 0x010 and issues its left half.
3. Jump to right half: `jump_addr`=0x020, `jump_right`=1; word[0x020]=0x00_000_05_030.
   - Expect `opcode`=0x05, `operand_addr`=0x030, `pc`=0x021.
   - Next fetch goes to memory.
4. PC wrap: right-half issue at `pc`=0xFFF -> `pc`=0x000.
5. Reset during WAIT:
   - All outputs return to reset values; a `mem_valid` pulse one cycle later produces no `instr_valid`.
   - Next fetch reads address 0.
6. `fetch_req`+`jump_en` in the same cycle -> only the PC is loaded, `mem_rd` stays 0. `fetch_req` during WAIT -> no second read, a single `instr_valid`.
